pipe_stall_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage CPU pipeline. It drives the write enables and synchronous-clear (bubble) controls of the PC and the F/D, D/X, X/M and M/W pipeline latches. It resolves load-use hazards, multi-cycle mult/div waits, taken branches and writeback-stage exceptions under a fixed priority. It also sequences a multdiv wait state machine with a timeout watchdog.

---
 rtl/pipe_stall_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush controller for the 5-stage pipeline.
// It drives the write enables and bubble (synchronous clear) controls of the
// PC and the F/D, D/X, X/M and M/W latches. It resolves, in priority order:
// writeback exceptions, multdiv waits, taken branches and load-use hazards.
// A multdiv wait is bounded by a watchdog of MD_TIMEOUT cycles.
// Optional feature macro: PIPE_CTRL_PERF_EN enables the stall_cycles counter.
//
// Handshake note: the controller has no valid/ready pairs of its own. Each
// flush output is meaningful only while the matching wren is 1. md_ready is
// a single-cycle "result valid" strobe from the multdiv unit. It is sampled
// only while a mul/div sits in X (dx_md_start=1) or while in MD_WAIT.
module pipe_stall_ctrl #(
    parameter int MD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  fd_rs,
    input  logic [4:0]  fd_rt,
    input  logic        fd_uses_rs,
    input  logic        fd_uses_rt,
    input  logic        dx_is_load,
    input  logic [4:0]  dx_rd,
    input  logic        dx_md_start,
    input  logic        md_ready,
    input  logic        dx_branch_taken,
    input  logic        mw_exception,
    output logic        pc_wren,
    output logic        fd_wren,
    output logic        dx_wren,
    output logic        xm_wren,
    output logic        mw_wren,
    output logic        fd_flush,
    output logic        dx_flush,
    output logic        xm_flush,
    output logic        md_busy,
    output logic        md_timeout,
    output logic [31:0] stall_cycles
);

    localparam int CW = $clog2(MD_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MD_WAIT   = 2'd1,
        ST_EXC_FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            md_timeout_q, md_timeout_d;
    logic            load_use;

    // Load-use hazard: a load in X writes a register that the instruction in D reads.
    always_comb begin
        load_use = dx_is_load && (dx_rd != 5'd0) &&
                   ((fd_uses_rs && (fd_rs == dx_rd)) ||
                    (fd_uses_rt && (fd_rt == dx_rd)));
    end

    // Next state, wait counter and latch controls, resolved under fixed priority.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        md_timeout_d = md_timeout_q;
        pc_wren      = 1'b1;
        fd_wren      = 1'b1;
        dx_wren      = 1'b1;
        xm_wren      = 1'b1;
        mw_wren      = 1'b1;
        fd_flush     = 1'b0;
        dx_flush     = 1'b0;
        xm_flush     = 1'b0;
        md_busy      = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mw_exception) begin
                    fd_flush = 1'b1;
                    dx_flush = 1'b1;
                    xm_flush = 1'b1;
                    state_d  = ST_EXC_FLUSH;
                end else if (dx_md_start && !md_ready) begin
                    // Hold the front end; bubble into X/M while M/W drains.
                    pc_wren  = 1'b0;
                    fd_wren  = 1'b0;
                    dx_wren  = 1'b0;
                    xm_flush = 1'b1;
                    cnt_d    = CNT_ONE;
                    state_d  = ST_MD_WAIT;
                end else if (dx_branch_taken) begin
                    fd_flush = 1'b1;
                    dx_flush = 1'b1;
                end else if (load_use) begin
                    pc_wren  = 1'b0;
                    fd_wren  = 1'b0;
                    dx_flush = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                md_busy = 1'b1;
                if (mw_exception) begin
                    // Exception aborts the wait.
                    fd_flush = 1'b1;
                    dx_flush = 1'b1;
                    xm_flush = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_EXC_FLUSH;
                end else if (md_ready || (cnt_q == CNT_LAST)) begin
                    // Result (or forced release) is captured into X/M this cycle.
                    cnt_d   = '0;
                    state_d = ST_RUN;
                    if (!md_ready) begin
                        md_timeout_d = 1'b1;
                    end
                end else begin
                    pc_wren  = 1'b0;
                    fd_wren  = 1'b0;
                    dx_wren  = 1'b0;
                    xm_flush = 1'b1;
                    cnt_d    = cnt_q + CNT_ONE;
                end
            end
            ST_EXC_FLUSH: begin
                // One quiet cycle after an exception flush; all events ignored.
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase

        // While reset is asserted the pipeline is frozen and nothing is flushed.
        if (!reset) begin
            pc_wren  = 1'b0;
            fd_wren  = 1'b0;
            dx_wren  = 1'b0;
            xm_wren  = 1'b0;
            mw_wren  = 1'b0;
            fd_flush = 1'b0;
            dx_flush = 1'b0;
            xm_flush = 1'b0;
            md_busy  = 1'b0;
        end
    end

    // State, wait counter and sticky timeout flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    assign md_timeout = md_timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of cycles in which the PC was held.
    always_comb begin
        stall_d = stall_q;
        if (!pc_wren && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed testbench for pipe_stall_ctrl (MD_TIMEOUT=8).
// Control outputs are packed as {pc,fd,dx,xm,mw wren, fd,dx,xm flush, md_busy}.
module tb_pipe_stall_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [8:0] C_RST  = 9'b00000_000_0;
    localparam logic [8:0] C_DEF  = 9'b11111_000_0;
    localparam logic [8:0] C_LU   = 9'b00111_010_0;
    localparam logic [8:0] C_BR   = 9'b11111_110_0;
    localparam logic [8:0] C_EXC  = 9'b11111_111_0;
    localparam logic [8:0] C_EXCB = 9'b11111_111_1;
    localparam logic [8:0] C_MDE  = 9'b00011_001_0;
    localparam logic [8:0] C_MDW  = 9'b00011_001_1;
    localparam logic [8:0] C_MDR  = 9'b11111_000_1;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  fd_rs, fd_rt, dx_rd;
    logic        fd_uses_rs, fd_uses_rt, dx_is_load;
    logic        dx_md_start, md_ready, dx_branch_taken, mw_exception;
    logic        pc_wren, fd_wren, dx_wren, xm_wren, mw_wren;
    logic        fd_flush, dx_flush, xm_flush, md_busy, md_timeout;
    logic [31:0] stall_cycles;
    logic [8:0]  ctl;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_stall = 32'd0;

    // Clock generation.
    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MD_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .fd_rs(fd_rs), .fd_rt(fd_rt),
        .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
        .dx_is_load(dx_is_load), .dx_rd(dx_rd),
        .dx_md_start(dx_md_start), .md_ready(md_ready),
        .dx_branch_taken(dx_branch_taken), .mw_exception(mw_exception),
        .pc_wren(pc_wren), .fd_wren(fd_wren), .dx_wren(dx_wren),
        .xm_wren(xm_wren), .mw_wren(mw_wren),
        .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush),
        .md_busy(md_busy), .md_timeout(md_timeout),
        .stall_cycles(stall_cycles)
    );

    assign ctl = {pc_wren, fd_wren, dx_wren, xm_wren, mw_wren,
                  fd_flush, dx_flush, xm_flush, md_busy};

    task automatic clear_inputs();
        fd_rs = 5'd0; fd_rt = 5'd0; dx_rd = 5'd0;
        fd_uses_rs = 1'b0; fd_uses_rt = 1'b0; dx_is_load = 1'b0;
        dx_md_start = 1'b0; md_ready = 1'b0;
        dx_branch_taken = 1'b0; mw_exception = 1'b0;
    endtask

    // Check the controls for the current cycle, then advance to the next cycle.
    task automatic cyc(input string tag, input logic [8:0] exp);
        #1;
        checks++;
        assert (ctl === exp) else begin
            errors++;
            $error("FAIL %s: ctl observed %b expected %b", tag, ctl, exp);
        end
        if (!reset) exp_stall = 32'd0;
        else if (!exp[8]) exp_stall = exp_stall + 32'd1;
        @(negedge clk);
    endtask

    task automatic chk_stat(input string tag, input logic exp_to);
        logic [31:0] exp_sc;
        exp_sc = PERF ? exp_stall : 32'd0;
        checks++;
        assert (md_timeout === exp_to) else begin
            errors++;
            $error("FAIL %s_timeout: observed %b expected %b", tag, md_timeout, exp_to);
        end
        checks++;
        assert (stall_cycles === exp_sc) else begin
            errors++;
            $error("FAIL %s_stall: observed %0d expected %0d", tag, stall_cycles, exp_sc);
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);

        // Reset: everything frozen, even with a branch asserted.
        cyc("rst0", C_RST);
        dx_branch_taken = 1'b1;
        cyc("rst_branch", C_RST);
        chk_stat("rst", 1'b0);
        clear_inputs();
        reset = 1'b1;
        cyc("run_def", C_DEF);

        // Load-use on rs, then quiet cycle.
        dx_is_load = 1'b1; dx_rd = 5'd5; fd_rs = 5'd5; fd_uses_rs = 1'b1;
        cyc("lu_rs", C_LU);
        clear_inputs();
        cyc("lu_after", C_DEF);
        // Load-use on rt; same match without uses_rt is no hazard.
        dx_is_load = 1'b1; dx_rd = 5'd7; fd_rt = 5'd7; fd_uses_rt = 1'b1;
        cyc("lu_rt", C_LU);
        fd_uses_rt = 1'b0;
        cyc("lu_rt_unused", C_DEF);
        // r0 destination never stalls.
        dx_rd = 5'd0; fd_rs = 5'd0; fd_uses_rs = 1'b1;
        cyc("lu_r0", C_DEF);
        // Branch alone, then branch together with load-use.
        clear_inputs();
        dx_branch_taken = 1'b1;
        cyc("branch", C_BR);
        dx_is_load = 1'b1; dx_rd = 5'd9; fd_rs = 5'd9; fd_uses_rs = 1'b1;
        cyc("branch_lu", C_BR);
        clear_inputs();
        // Multdiv already ready: no stall.
        dx_md_start = 1'b1; md_ready = 1'b1;
        cyc("md_ready_now", C_DEF);

        // Multdiv with ready on the 4th cycle after start.
        md_ready = 1'b0;
        cyc("md_enter", C_MDE);
        for (int i = 0; i < 3; i++) cyc("md_wait", C_MDW);
        md_ready = 1'b1;
        cyc("md_release", C_MDR);
        clear_inputs();
        cyc("md_after", C_DEF);
        chk_stat("md", 1'b0);

        // Watchdog: ready never comes.
        dx_md_start = 1'b1;
        cyc("to_enter", C_MDE);
        for (int i = 0; i < 6; i++) cyc("to_wait", C_MDW);
        chk_stat("to_pre", 1'b0);
        cyc("to_release", C_MDR);
        clear_inputs();
        chk_stat("to_post", 1'b1);
        cyc("to_after", C_DEF);

        // Exception aborts a multdiv wait; held high it is ignored in EXC_FLUSH.
        dx_md_start = 1'b1;
        cyc("mx_enter", C_MDE);
        cyc("mx_wait", C_MDW);
        mw_exception = 1'b1;
        cyc("mx_exc", C_EXCB);
        dx_branch_taken = 1'b1;
        cyc("mx_excflush", C_DEF);
        dx_md_start = 1'b0; dx_branch_taken = 1'b0;
        // Back-to-back exceptions from RUN.
        cyc("exc1", C_EXC);
        cyc("exc2_ignored", C_DEF);
        clear_inputs();
        cyc("exc_done", C_DEF);
        chk_stat("exc", 1'b1);

        // Reset in the middle of a wait.
        dx_md_start = 1'b1;
        cyc("rw_enter", C_MDE);
        cyc("rw_wait", C_MDW);
        reset = 1'b0;
        cyc("rw_reset", C_RST);
        chk_stat("rw_reset", 1'b0);
        reset = 1'b1;
        dx_md_start = 1'b0;
        cyc("rw_run", C_DEF);
        chk_stat("rw_run", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
